// File: rtl/mult_if.sv
// Handshake and result bus between the control unit and the Hi/Lo multiplier.
// MULT_MULTU_EN adds the mult_unsigned select for MULTU.
interface mult_if;
  logic        mult_start;
  logic [31:0] A;
  logic [31:0] B;
`ifdef MULT_MULTU_EN
  logic        mult_unsigned;
`endif
  logic        mult_done;
  logic [31:0] Hi;
  logic [31:0] Lo;

`ifdef MULT_MULTU_EN
  modport master (output mult_start, A, B, mult_unsigned, input mult_done, Hi, Lo);
  modport slave  (input mult_start, A, B, mult_unsigned, output mult_done, Hi, Lo);
`else
  modport master (output mult_start, A, B, input mult_done, Hi, Lo);
  modport slave  (input mult_start, A, B, output mult_done, Hi, Lo);
`endif
endinterface

// File: rtl/mult.sv
// Sequential 32x32 radix-2 Booth multiplier writing Hi/Lo after 32 steps.
// MULT_MULTU_EN adds an unsigned add-shift mode selected at start.
module mult (
  input  logic  clk,
  input  logic  reset,
  mult_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q;
  logic [5:0]  cnt_q;
  logic [32:0] acc_q, m_q;
  logic [31:0] q_q;
  logic        qm1_q;
  logic [31:0] hi_q, lo_q;
  logic        done_q;
`ifdef MULT_MULTU_EN
  logic        uns_q;
  logic [33:0] usum;
`endif

  logic [32:0] sum_d, acc_d, m_ld;
  logic [31:0] q_d;
  logic        qm1_d;

  // One recurrence step: optional add/sub, then shift {ACC, Q, q-1} right.
  always_comb begin
    sum_d = acc_q;
    case ({q_q[0], qm1_q})
      2'b01:   sum_d = acc_q + m_q;
      2'b10:   sum_d = acc_q - m_q;
      default: sum_d = acc_q;
    endcase
    acc_d = {sum_d[32], sum_d[32:1]};
    q_d   = {sum_d[0], q_q[31:1]};
    qm1_d = q_q[0];
    m_ld  = {bus.A[31], bus.A};
`ifdef MULT_MULTU_EN
    usum = {1'b0, acc_q} + (q_q[0] ? {1'b0, m_q} : 34'd0);
    if (uns_q) begin
      acc_d = usum[33:1];
      q_d   = {usum[0], q_q[31:1]};
    end
    if (bus.mult_unsigned) m_ld = {1'b0, bus.A};
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      m_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
`ifdef MULT_MULTU_EN
      uns_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      // A start in any state (re)loads; in RUN this aborts the product in flight.
      if (bus.mult_start) begin
        state_q <= RUN;
        cnt_q   <= 6'd32;
        acc_q   <= '0;
        m_q     <= m_ld;
        q_q     <= bus.B;
        qm1_q   <= 1'b0;
`ifdef MULT_MULTU_EN
        uns_q   <= bus.mult_unsigned;
`endif
      end else begin
        case (state_q)
          RUN: begin
            acc_q <= acc_d;
            q_q   <= q_d;
            qm1_q <= qm1_d;
            cnt_q <= cnt_q - 6'd1;
            if (cnt_q == 6'd1) begin
              hi_q    <= acc_d[31:0];
              lo_q    <= q_d;
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
          DONE:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.mult_done = done_q;
  assign bus.Hi        = hi_q;
  assign bus.Lo        = lo_q;
endmodule
